// File: rtl/onchip_mem_pkg.sv
// Shared types and defaults for the on-chip RAM copy/fill master and its RAM wrapper.
package onchip_mem_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LEN_W  = DEF_ADDR_W + 1;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COPY_RD = 3'd1,
    COPY_WR = 3'd2,
    FILL_WR = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/onchip_mem_copy_master.sv
// Avalon-MM master performing block COPY (2 cycles/word) or FILL (1 cycle/word) on a
// single-port on-chip RAM with 1-cycle read latency; start/abort control, busy/done status.
module onchip_mem_copy_master
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [ADDR_W-1:0]   src_addr_i,
  input  logic [ADDR_W-1:0]   dst_addr_i,
  input  logic [LEN_W-1:0]    length_i,
  input  logic [DATA_W-1:0]   fill_data_i,
  input  logic                abort_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [LEN_W-1:0]    words_done_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W/8-1:0] byteenable_o,
  output logic                chipselect_o,
  output logic                write_o,
  output logic [DATA_W-1:0]   writedata_o,
  output logic                clken_o,
  input  logic [DATA_W-1:0]   readdata_i
);

  state_e              state_q;
  logic [ADDR_W-1:0]   src_q, dst_q, addr_q;
  logic [LEN_W-1:0]    rem_q, words_done_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                cs_q, we_q, busy_q, done_q;

  logic [ADDR_W-1:0]   src_d, dst_d;
  logic [LEN_W-1:0]    rem_d, words_done_d;
  logic                last_d;

  // Address counters wrap naturally at 2**ADDR_W.
  assign src_d        = src_q + 1'b1;
  assign dst_d        = dst_q + 1'b1;
  assign rem_d        = rem_q - 1'b1;
  assign words_done_d = words_done_q + 1'b1;
  assign last_d       = (rem_q == LEN_W'(1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      words_done_q <= '0;
      wdata_q      <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            src_q        <= src_addr_i;
            dst_q        <= dst_addr_i;
            rem_q        <= length_i;
            words_done_q <= '0;
            if (length_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (mode_i == MODE_FILL) begin
              state_q <= FILL_WR;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= dst_addr_i;
              wdata_q <= fill_data_i;
            end else begin
              state_q <= COPY_RD;
              busy_q  <= 1'b1;
              cs_q    <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= src_addr_i;
            end
          end
        end
        COPY_RD: begin
          if (abort_i) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= COPY_WR;
            we_q    <= 1'b1;
            addr_q  <= dst_q;
          end
        end
        COPY_WR: begin
          // The write on the bus lands at this edge even when aborted, so it is counted.
          src_q        <= src_d;
          dst_q        <= dst_d;
          rem_q        <= rem_d;
          words_done_q <= words_done_d;
          wdata_q      <= readdata_i;
          if (abort_i || last_d) begin
            state_q <= abort_i ? IDLE : DONE;
            done_q  <= !abort_i;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= COPY_RD;
            we_q    <= 1'b0;
            addr_q  <= src_d;
          end
        end
        FILL_WR: begin
          dst_q        <= dst_d;
          rem_q        <= rem_d;
          words_done_q <= words_done_d;
          if (abort_i || last_d) begin
            state_q <= abort_i ? IDLE : DONE;
            done_q  <= !abort_i;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            addr_q <= dst_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM read data only arrives during COPY_WR, so it is forwarded straight to the bus there.
  assign writedata_o  = (state_q == COPY_WR) ? readdata_i : wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign words_done_o = words_done_q;
  assign address_o    = addr_q;
  assign chipselect_o = cs_q;
  assign write_o      = we_q;
  assign byteenable_o = '1;
  assign clken_o      = 1'b1;

endmodule
